turn_timer_ctrl: RTL and testbench
==================================

# turn_timer_ctrl

Turn countdown sequencer for the game. Divides `clk` into a 1 s timebase, counts a turn down from `TURN_SECONDS` to 0 and drives the 4-bit `seconds` code consumed directly by the 7-segment decoder. Code 10 displays "A", and codes 11..15 blank the display. Signals turn expiry to the game FSM with a one-cycle `timeout` pulse.

## Interface
- `CLK_HZ`, default 50_000_000: `clk` cycles per second (prescaler terminal count); legal range ≥ 2, even.
- `TURN_SECONDS`, default 10: value loaded on `start`; legal range 1..10.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset; one clock, synchronous, active-low.
- `start`  in  1  pulse; load `TURN_SECONDS` and run (restarts if already running).
- `hold`  in  1  level; freeze countdown and prescaler while high.
- `cancel`  in  1  pulse; abort turn, return to IDLE.
- `seconds`  out  4  display code to 7-seg decoder.
- `running`  out  1  high in RUN state (including while held).
- `tick`  out  1  one-cycle pulse on every decrement.
- `timeout`  out  1  one-cycle pulse when count reaches 0.

## Operation
- States:
  - IDLE: `seconds` = 4'd15 (blank).
  - RUN: counting down.
  - EXPIRED: `seconds` = 0 shown until next `start` or `cancel`.
- Reset (`rst` low at posedge): state IDLE, count 0, prescaler 0, `seconds` = 15, `running` = 0, `tick` = 0, `timeout` = 0.
- Input priority per cycle: `cancel` > `start` > `hold`.
- `cancel` from any state goes to IDLE and clears the prescaler.
- `start` from any state loads count = `TURN_SECONDS`, clears the prescaler and enters RUN.
- RUN with `hold` low: prescaler increments each cycle. At `CLK_HZ-1` it wraps to 0, count decrements and `tick` pulses.
  - If the decrement goes 1→0: `timeout` pulses in the same cycle and the state moves to EXPIRED.
- RUN with `hold` high: prescaler and count are frozen. `running` stays 1. No `tick`.
- `hold` has no effect in IDLE or EXPIRED.
- `start` and `cancel` are ignored while `rst` is low.
- Mid-turn reset fully aborts the turn; no `timeout` is emitted.
- Count is never below 0 and never above 10. Prescaler width is `$clog2(CLK_HZ)`.

## Timing
- All outputs are registered.
- `start` sampled at edge N: from edge N+1, `seconds` = `TURN_SECONDS` and `running` = 1.
- First decrement comes exactly `CLK_HZ` unheld cycles after the `start` edge. Subsequent decrements follow every `CLK_HZ` unheld cycles.
- Count change, `tick` and `timeout` become visible on the same edge.
- Total turn is `TURN_SECONDS*CLK_HZ` unheld cycles from `start` to `timeout`.
- `start` coincident with the expiring wrap: the restart wins and no `timeout` pulse is emitted.
- `cancel` coincident with `start`: the state goes to IDLE.

## Configuration
- `TURN_TIMER_BLINK_EN` defined: in RUN with count ≤ 3 and count ≥ 1, `seconds` outputs 15 (blank) while prescaler ≥ `CLK_HZ/2`, and the count otherwise. This gives a 1 Hz, 50 % duty blink for the final seconds.
  - While `hold` is high, the frozen prescaler freezes the blink phase.
  - Internal count, `tick` and `timeout` are unchanged.
- Not defined: `seconds` always reflects the state rules above with no blanking in RUN.

## Test plan
- Reset/idle: `CLK_HZ`=4, `TURN_SECONDS`=10; hold `rst` low 3 cycles, then release -> `seconds` = 15, `running` = 0, `tick` = `timeout` = 0. Idle for 20 cycles -> no change.
- Full countdown: pulse `start` -> `seconds` = 10 on next edge, then decrements every 4 cycles with `tick` each time. `timeout` pulses once exactly 40 cycles after `start`, with `seconds` = 0 and `running` = 0 thereafter.
- Hold: after `start`, raise `hold` for 7 cycles at prescaler = 2 -> count and prescaler frozen, `running` = 1. Timeout arrives at 47 cycles instead of 40.
- Restart/cancel priority: `start` at count 3 -> `seconds` = 10, prescaler restarts. `start` and `cancel` in the same cycle -> IDLE, `seconds` = 15, no `timeout`.
- Edge collision: `start` on the exact cycle the count goes 1→0 -> no `timeout` pulse, `seconds` = 10, state RUN. Reset asserted mid-turn at count 5 -> IDLE values next edge, no `timeout`.
- Blink (macro defined, `CLK_HZ`=4): at count 3, `seconds` reads 3,3,15,15 per prescaler period. At count 4, it reads 4 steadily. Without the macro, count 3 reads 3 steadily.

Source files
------------

// File: rtl/turn_timer_ctrl.sv
// turn_timer_ctrl: turn countdown sequencer for the game.
// Divides clk into a 1 s timebase, counts a turn down from TURN_SECONDS to 0,
// drives the 4-bit 7-segment display code and pulses timeout on expiry.
// Optional feature macro: TURN_TIMER_BLINK_EN blanks the display for the
// second half of each second while the count is 3..1 in RUN.
module turn_timer_ctrl #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TURN_SECONDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    input  logic       cancel,
    output logic [3:0] seconds,
    output logic       running,
    output logic       tick,
    output logic       timeout
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [3:0]    TURN_LOAD  = 4'(TURN_SECONDS);
`ifdef TURN_TIMER_BLINK_EN
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
`endif

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;

    localparam logic [3:0] SEG_BLANK = 4'd15;

    logic [1:0]    state_q,   state_d;
    logic [3:0]    count_q,   count_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [3:0]    seconds_q, seconds_d;
    logic          running_q, running_d;
    logic          tick_q,    tick_d;
    logic          timeout_q, timeout_d;

    // Next state, count and prescaler; priority cancel > start > hold
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        presc_d   = presc_q;
        tick_d    = 1'b0;
        timeout_d = 1'b0;
        if (cancel) begin
            state_d = ST_IDLE;
            count_d = '0;
            presc_d = '0;
        end else if (start) begin
            state_d = ST_RUN;
            count_d = TURN_LOAD;
            presc_d = '0;
        end else if (state_q == ST_RUN && !hold) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                count_d = count_q - 4'd1;
                tick_d  = 1'b1;
                if (count_q == 4'd1) begin
                    timeout_d = 1'b1;
                    state_d   = ST_EXPIRED;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Registered display code and status, derived from the next-state values
    always_comb begin
        seconds_d = SEG_BLANK;
        running_d = (state_d == ST_RUN);
        case (state_d)
            ST_RUN: begin
                seconds_d = count_d;
`ifdef TURN_TIMER_BLINK_EN
                if (count_d >= 4'd1 && count_d <= 4'd3 && presc_d >= PRESC_HALF)
                    seconds_d = SEG_BLANK;
`endif
            end
            ST_EXPIRED: seconds_d = 4'd0;
            default:    seconds_d = SEG_BLANK;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            seconds_q <= SEG_BLANK;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            seconds_q <= seconds_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            timeout_q <= timeout_d;
        end
    end

    assign seconds = seconds_q;
    assign running = running_q;
    assign tick    = tick_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_turn_timer_ctrl.sv
// Self-checking bench for turn_timer_ctrl with CLK_HZ=4, TURN_SECONDS=10.
// Reference model tracks unheld cycles elapsed since start and derives the
// count, tick and timeout arithmetically. Honours TURN_TIMER_BLINK_EN.
module tb_turn_timer_ctrl;

    localparam int CLK_HZ = 4;
    localparam int TURN   = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic       cancel = 1'b0;
    logic [3:0] seconds;
    logic       running;
    logic       tick;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 idle, 1 run, 2 expired
    int m_state = 0;
    int m_el    = 0;
    int m_tick  = 0;
    int m_to    = 0;

    turn_timer_ctrl #(.CLK_HZ(CLK_HZ), .TURN_SECONDS(TURN)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .hold    (hold),
        .cancel  (cancel),
        .seconds (seconds),
        .running (running),
        .tick    (tick),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_seconds();
        int cnt;
        if (m_state == 0) return 15;
        if (m_state == 2) return 0;
        cnt = TURN - m_el / CLK_HZ;
`ifdef TURN_TIMER_BLINK_EN
        if (cnt >= 1 && cnt <= 3 && (m_el % CLK_HZ) >= CLK_HZ / 2) return 15;
`endif
        return cnt;
    endfunction

    // Apply inputs, clock one edge, advance model, compare all outputs
    task automatic step(input logic r, input logic s, input logic h, input logic c);
        rst = r; start = s; hold = h; cancel = c;
        @(posedge clk);
        m_tick = 0;
        m_to   = 0;
        if (!r) begin
            m_state = 0; m_el = 0;
        end else if (c) begin
            m_state = 0; m_el = 0;
        end else if (s) begin
            m_state = 1; m_el = 0;
        end else if (m_state == 1 && !h) begin
            m_el++;
            if (m_el % CLK_HZ == 0) m_tick = 1;
            if (m_el == TURN * CLK_HZ) begin
                m_to = 1; m_state = 2;
            end
        end
        #1;
        check("seconds", int'(seconds), exp_seconds());
        check("running", int'(running), (m_state == 1) ? 1 : 0);
        check("tick",    int'(tick),    m_tick);
        check("timeout", int'(timeout), m_to);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int lat;
        logic h_lvl;

        // reset 3 cycles, then idle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        idle_n(20);

        // full countdown: measure start-to-timeout latency
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("start_load", int'(seconds), TURN);
        lat = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (timeout) lat = k;
        end
        check("to_latency", lat, TURN * CLK_HZ);
        idle_n(5);

        // hold for 7 cycles at prescaler 2
        step(1'b1, 1'b1, 1'b0, 1'b0);
        lat = -1;
        for (int k = 1; k <= 80 && lat < 0; k++) begin
            step(1'b1, 1'b0, (k >= 3 && k <= 9) ? 1'b1 : 1'b0, 1'b0);
            if (timeout) lat = k;
        end
        check("hold_latency", lat, TURN * CLK_HZ + 7);

        // restart at count 3, then start+cancel together
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle_n(28);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle_n(6);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("cancel_wins", int'(seconds), 15);
        idle_n(4);

        // start coincident with the expiring wrap
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle_n(TURN * CLK_HZ - 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("collide_sec", int'(seconds), TURN);
        idle_n(3);

        // reset mid-turn at count 5
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle_n(5 * CLK_HZ);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle_n(10);

        // blink / steady display around the final seconds
        step(1'b1, 1'b1, 1'b0, 1'b0);
        idle_n(TURN * CLK_HZ + 3);

        // randomized traffic
        h_lvl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) h_lvl = ~h_lvl;
            step(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                 h_lvl,
                 ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
